// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline sequencer for the 5-stage core (F, D, E, M, W). It tracks which
//   registers are still being written by instructions in Execute and Memory.
//   Decode is stalled on a read-after-write hazard, because the datapath has
//   no forwarding. A taken branch flushes F/D and D/E. Stall and flush cycles
//   are counted in saturating performance counters.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   dec_*           Decode instruction: valid, source/dest addresses,
//                   operand-use flags, register-write flag
//   branch_taken    Execute resolved a taken branch this cycle
//   fd_en..mw_en    inter-stage buffer enables
//   fd_flush        load a NOP into F/D
//   de_bubble       load a NOP control word into D/E
//   state           0 RUN, 1 STALL, 2 FLUSH
//   stall_cnt       saturating count of stall cycles
//   flush_cnt       saturating count of flush cycles
module hazard_stall_ctrl #(
  parameter int N            = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [N-1:0]     dec_src,
  input  logic [N-1:0]     dec_dst,
  input  logic             dec_uses_src,
  input  logic             dec_uses_dst,
  input  logic             dec_reg_write,
  input  logic             branch_taken,
  output logic             fd_en,
  output logic             de_en,
  output logic             em_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t           state_reg;
  logic [1:0]       flush_ctr_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // Writer scoreboard: entry 0 = Execute, entry 1 = Memory.
  // The register file writes before it reads, so a writer that has reached
  // WriteBack can never cause a hazard; its entry would never be looked at
  // and is therefore not kept.
  logic         sb_valid_reg [2];
  logic [N-1:0] sb_wa_reg    [2];

  logic [1:0] src_match;
  logic [1:0] dst_match;
  logic       hazard;
  logic       flush_active;
  logic       stall_active;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      assign src_match[gi] = sb_valid_reg[gi] && (sb_wa_reg[gi] == dec_src);
      assign dst_match[gi] = sb_valid_reg[gi] && (sb_wa_reg[gi] == dec_dst);
    end
  endgenerate

  assign hazard = dec_valid &&
                  ((dec_uses_src && (|src_match)) || (dec_uses_dst && (|dst_match)));

  // A branch (or an ongoing flush) overrides a hazard: the stalled Decode
  // instruction is discarded rather than held.
  assign flush_active = branch_taken || (state_reg == ST_FLUSH);
  assign stall_active = hazard && !flush_active;

  assign fd_en     = !stall_active;
  assign de_en     = 1'b1;
  assign em_en     = 1'b1;
  assign mw_en     = 1'b1;
  assign fd_flush  = flush_active;
  assign de_bubble = flush_active || stall_active;
  assign state     = state_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

  // Scoreboard shift. A bubble enters Execute as an invalid writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid_reg[0] <= 1'b0;
      sb_wa_reg[0]    <= '0;
      sb_valid_reg[1] <= 1'b0;
      sb_wa_reg[1]    <= '0;
    end else begin
      sb_valid_reg[0] <= dec_valid && dec_reg_write && !de_bubble;
      sb_wa_reg[0]    <= dec_dst;
      sb_valid_reg[1] <= sb_valid_reg[0];
      sb_wa_reg[1]    <= sb_wa_reg[0];
    end
  end

  // Sequencer FSM and flush-length counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      flush_ctr_reg <= 2'd0;
    end else if (branch_taken) begin
      flush_ctr_reg <= FLUSH_LOAD;
      state_reg     <= (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
    end else begin
      case (state_reg)
        ST_FLUSH: begin
          // Counter holds the number of flush cycles still to come,
          // including this one minus the branch cycle.
          if (flush_ctr_reg <= 2'd1) begin
            flush_ctr_reg <= 2'd0;
            state_reg     <= ST_RUN;
          end else begin
            flush_ctr_reg <= flush_ctr_reg - 2'd1;
          end
        end
        default: state_reg <= hazard ? ST_STALL : ST_RUN;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_active && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_active && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl. Two instances share one input stream:
// instance 0 with FLUSH_CYCLES=1, CNT_W=16 and instance 1 with FLUSH_CYCLES=3,
// CNT_W=4. A reference model keeps the last two issued writes as a short
// history and checks both instances every cycle outside reset.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dec_valid, dec_uses_src, dec_uses_dst, dec_reg_write, branch_taken;
  logic [2:0] dec_src, dec_dst;

  logic        a_fd_en, a_de_en, a_em_en, a_mw_en, a_fd_flush, a_de_bubble;
  logic [1:0]  a_state;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_fd_en, b_de_en, b_em_en, b_mw_en, b_fd_flush, b_de_bubble;
  logic [1:0]  b_state;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  hazard_stall_ctrl #(.N(3), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src), .dec_dst(dec_dst),
    .dec_uses_src(dec_uses_src), .dec_uses_dst(dec_uses_dst), .dec_reg_write(dec_reg_write),
    .branch_taken(branch_taken), .fd_en(a_fd_en), .de_en(a_de_en), .em_en(a_em_en),
    .mw_en(a_mw_en), .fd_flush(a_fd_flush), .de_bubble(a_de_bubble), .state(a_state),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_stall_ctrl #(.N(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src), .dec_dst(dec_dst),
    .dec_uses_src(dec_uses_src), .dec_uses_dst(dec_uses_dst), .dec_reg_write(dec_reg_write),
    .branch_taken(branch_taken), .fd_en(b_fd_en), .de_en(b_de_en), .em_en(b_em_en),
    .mw_en(b_mw_en), .fd_flush(b_fd_flush), .de_bubble(b_de_bubble), .state(b_state),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  int tests = 0;
  int fails = 0;

  // Reference model: writes issued one and two cycles ago, flush cycles
  // still owed, whether last cycle stalled, and the two counters.
  bit         m_wv  [2][2];
  logic [2:0] m_wr  [2][2];
  int         m_rem [2];
  bit         m_pstall [2];
  int         m_sc  [2];
  int         m_fc  [2];

  // Observations of the last step, used by the hand-computed checks.
  logic       o_fd_en, o_de_bubble, o_fd_flush, o2_fd_flush;
  logic [1:0] o_state, o2_state;

  function automatic int fcyc(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic bit in_flight(int k, logic [2:0] a);
    return (m_wv[k][0] && m_wr[k][0] == a) || (m_wv[k][1] && m_wr[k][1] == a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic fe, de, em, mw, ff, db,
                            input logic [1:0] st, input logic [31:0] sc, fc,
                            input bit hz, input bit fl);
    string p;
    p = (k == 0) ? "i0" : "i1";
    chk({p, ".fd_en"},     {31'b0, fe}, {31'b0, fl || !hz});
    chk({p, ".de_en"},     {31'b0, de}, 32'd1);
    chk({p, ".em_en"},     {31'b0, em}, 32'd1);
    chk({p, ".mw_en"},     {31'b0, mw}, 32'd1);
    chk({p, ".fd_flush"},  {31'b0, ff}, {31'b0, fl});
    chk({p, ".de_bubble"}, {31'b0, db}, {31'b0, fl || hz});
    chk({p, ".state"},     {30'b0, st}, (m_rem[k] > 0) ? 32'd2 : (m_pstall[k] ? 32'd1 : 32'd0));
    chk({p, ".stall_cnt"}, sc, m_sc[k]);
    chk({p, ".flush_cnt"}, fc, m_fc[k]);
  endtask

  // One clock cycle: drive inputs, compare after settling, advance the model.
  task automatic step(input bit r, input bit v, input logic [2:0] s, input logic [2:0] d,
                      input bit us, input bit ud, input bit rw, input bit b);
    bit hz [2];
    bit fl [2];
    rst = r; dec_valid = v; dec_src = s; dec_dst = d;
    dec_uses_src = us; dec_uses_dst = ud; dec_reg_write = rw; branch_taken = b;
    #1;
    for (int k = 0; k < 2; k++) begin
      hz[k] = v && ((us && in_flight(k, s)) || (ud && in_flight(k, d)));
      fl[k] = b || (m_rem[k] > 0);
    end
    if (!r) begin
      check_inst(0, a_fd_en, a_de_en, a_em_en, a_mw_en, a_fd_flush, a_de_bubble, a_state,
                 {16'b0, a_stall_cnt}, {16'b0, a_flush_cnt}, hz[0], fl[0]);
      check_inst(1, b_fd_en, b_de_en, b_em_en, b_mw_en, b_fd_flush, b_de_bubble, b_state,
                 {28'b0, b_stall_cnt}, {28'b0, b_flush_cnt}, hz[1], fl[1]);
    end
    o_fd_en = a_fd_en; o_de_bubble = a_de_bubble; o_fd_flush = a_fd_flush; o_state = a_state;
    o2_fd_flush = b_fd_flush; o2_state = b_state;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_wv[k][0] = 0; m_wv[k][1] = 0; m_wr[k][0] = '0; m_wr[k][1] = '0;
        m_rem[k] = 0; m_pstall[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        bit stalled;
        stalled = hz[k] && !fl[k];
        m_wv[k][1] = m_wv[k][0];
        m_wr[k][1] = m_wr[k][0];
        m_wv[k][0] = v && rw && !(fl[k] || hz[k]);
        m_wr[k][0] = d;
        if (stalled && m_sc[k] < cmax(k)) m_sc[k]++;
        if (fl[k] && m_fc[k] < cmax(k)) m_fc[k]++;
        if (b) m_rem[k] = fcyc(k) - 1;
        else if (m_rem[k] > 0) m_rem[k]--;
        m_pstall[k] = stalled;
      end
    end
    @(negedge clk);
  endtask

  // Issue one instruction, repeating it while Decode is held.
  task automatic issue(input bit v, input logic [2:0] s, input logic [2:0] d,
                       input bit us, input bit ud, input bit rw, output int stalls);
    stalls = 0;
    step(0, v, s, d, us, ud, rw, 0);
    while (!o_fd_en && stalls < 6) begin
      stalls++;
      step(0, v, s, d, us, ud, rw, 0);
    end
    if (stalls >= 6) begin
      tests++;
      fails++;
      $display("FAIL stall_bound: got %0d expected at most 5", stalls);
    end
  endtask

  task automatic nop();
    step(0, 0, 3'd0, 3'd0, 0, 0, 0, 0);
  endtask

  initial begin
    int ns;
    logic [4:0] pat;
    logic [2:0] rs, rd;
    bit rv, rus, rud, rrw, rb, last_b;

    rst = 1; dec_valid = 0; dec_src = 0; dec_dst = 0;
    dec_uses_src = 0; dec_uses_dst = 0; dec_reg_write = 0; branch_taken = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset state and independent instructions.
    step(0, 1, 3'd0, 3'd1, 0, 0, 1, 0);
    chk("rst.fd_en", {31'b0, o_fd_en}, 32'd1);
    chk("rst.de_bubble", {31'b0, o_de_bubble}, 32'd0);
    chk("rst.state", {30'b0, o_state}, 32'd0);
    chk("rst.stall_cnt", {16'b0, a_stall_cnt}, 32'd0);
    issue(1, 3'd0, 3'd2, 0, 0, 1, ns);  chk("indep1.stalls", ns, 0);
    issue(1, 3'd0, 3'd4, 0, 0, 1, ns);  chk("indep2.stalls", ns, 0);
    issue(1, 3'd0, 3'd7, 0, 0, 1, ns);  chk("indep3.stalls", ns, 0);
    nop(); nop();

    // Writer in E: two stall cycles.
    issue(1, 3'd0, 3'd3, 0, 0, 1, ns);
    issue(1, 3'd3, 3'd0, 1, 0, 0, ns);
    chk("rawE.stalls", ns, 2);
    chk("rawE.stall_cnt", {16'b0, a_stall_cnt}, 32'd2);

    // Writer in M: one stall cycle.
    issue(1, 3'd0, 3'd5, 0, 0, 1, ns);
    issue(1, 3'd0, 3'd1, 0, 0, 0, ns);
    issue(1, 3'd0, 3'd5, 0, 1, 0, ns);
    chk("rawM.stalls", ns, 1);
    chk("rawM.stall_cnt", {16'b0, a_stall_cnt}, 32'd3);

    // Writer in W: no stall.
    issue(1, 3'd0, 3'd6, 0, 0, 1, ns);
    issue(1, 3'd0, 3'd1, 0, 0, 0, ns);
    issue(1, 3'd0, 3'd2, 0, 0, 0, ns);
    issue(1, 3'd6, 3'd0, 1, 0, 0, ns);
    chk("rawW.stalls", ns, 0);
    nop(); nop();

    // Branch in the same cycle as a hazard: flush wins.
    issue(1, 3'd0, 3'd2, 0, 0, 1, ns);
    step(0, 1, 3'd2, 3'd0, 1, 0, 0, 1);
    chk("brhz.fd_flush", {31'b0, o_fd_flush}, 32'd1);
    chk("brhz.de_bubble", {31'b0, o_de_bubble}, 32'd1);
    chk("brhz.fd_en", {31'b0, o_fd_en}, 32'd1);
    chk("brhz.stall_cnt", {16'b0, a_stall_cnt}, 32'd3);
    chk("brhz.flush_cnt", {16'b0, a_flush_cnt}, 32'd1);
    nop(); nop(); nop();

    // Three-cycle flush re-armed in its second cycle: four flush cycles.
    step(0, 0, 0, 0, 0, 0, 0, 1); pat[0] = o2_fd_flush;
    step(0, 0, 0, 0, 0, 0, 0, 1); pat[1] = o2_fd_flush;
    chk("reflush.state1", {30'b0, o2_state}, 32'd2);
    nop(); pat[2] = o2_fd_flush; chk("reflush.state2", {30'b0, o2_state}, 32'd2);
    nop(); pat[3] = o2_fd_flush; chk("reflush.state3", {30'b0, o2_state}, 32'd2);
    nop(); pat[4] = o2_fd_flush;
    chk("reflush.pattern", {27'b0, pat}, 32'h0f);
    nop();

    // Reset during the first stall cycle clears everything.
    issue(1, 3'd0, 3'd3, 0, 0, 1, ns);
    step(1, 1, 3'd3, 3'd0, 1, 0, 0, 0);
    step(0, 1, 3'd3, 3'd0, 1, 0, 0, 0);
    chk("rststall.fd_en", {31'b0, o_fd_en}, 32'd1);
    chk("rststall.state", {30'b0, o_state}, 32'd0);
    chk("rststall.stall_cnt", {16'b0, a_stall_cnt}, 32'd0);
    chk("rststall.flush_cnt", {16'b0, a_flush_cnt}, 32'd0);

    // Random traffic. Decode is held while stalled and carries a NOP
    // after a flush, as the real F/D buffer would.
    last_b = 0;
    rv = 0; rs = 0; rd = 0; rus = 0; rud = 0; rrw = 0;
    repeat (3000) begin
      if (!m_pstall[0]) begin
        rv  = ($urandom_range(0, 3) != 0);
        rs  = 3'($urandom_range(0, 7));
        rd  = 3'($urandom_range(0, 7));
        rus = $urandom_range(0, 1) == 1;
        rud = $urandom_range(0, 3) == 0;
        rrw = $urandom_range(0, 3) != 0;
        if (last_b || m_rem[1] > 0) rv = 0;
      end
      rb = ($urandom_range(0, 11) == 0);
      step(0, rv, rs, rd, rus, rud, rrw, rb);
      last_b = rb;
    end

    // Narrow counters must have saturated and held.
    chk("sat.flush_cnt", {28'b0, b_flush_cnt}, 32'd15);
    chk("sat.stall_cnt", {28'b0, b_stall_cnt}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
